// File: rtl/turf_pkg.sv
// turf_pkg: shared definitions for the TURF hold scheduler.
//   NUM_SURFS_DEF / NUM_HOLD_DEF / EVNUM_WIDTH_DEF : default geometry
//   clog2()                                        : buffer-index width helper
//   event_rec_t                                    : {buffer, event number} record
package turf_pkg;

  localparam int NUM_SURFS_DEF   = 12;
  localparam int NUM_HOLD_DEF    = 4;
  localparam int EVNUM_WIDTH_DEF = 32;

  // Number of bits needed to index 'value' items (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int BUF_W_DEF = clog2(NUM_HOLD_DEF);

  typedef struct packed {
    logic [BUF_W_DEF-1:0]       buf_id;
    logic [EVNUM_WIDTH_DEF-1:0] evnum;
  } event_rec_t;

endpackage

// File: rtl/turf_event_fifo.sv
// turf_event_fifo: first-word-fall-through FIFO.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   push_i, data_i : write a word
//   pop_i          : consume the head word (ignored when empty)
//   data_o         : head word, valid whenever empty_o is low
//   count_o        : number of stored words (0..DEPTH)
//   full_o/empty_o : status, decoded from the registered count
module turf_event_fifo
  import turf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [clog2(DEPTH):0]  count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    // A pop in the same cycle makes room, so push-while-full-and-popping is legal.
    do_push = push_i && (!full_o || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/turf_hold_scheduler.sv
// turf_hold_scheduler: allocates shared analog hold buffers in strict
// round-robin order, drives the HOLD lines to every SURF and queues
// {buffer, event number} records for readout.
//   clk125_i, rst_n_i        : clock, asynchronous active-low reset
//   enable_i, trig_i         : trigger-accept request (rejected when disabled)
//   buf_done_valid_i/_id_i   : readout of a buffer finished, release it
//   evnum_clear_i            : zero the event counter
//   hold_o                   : bit NUM_HOLD*i+k = buffer k held on SURF i
//   event_valid_o/_ready_i   : record handshake; event_buf_o/event_num_o payload
//   full_o                   : next round-robin buffer is still held
//   reject_count_o           : saturating count of rejected triggers
//   err_release_o            : sticky, a buffer was released while not held
module turf_hold_scheduler
  import turf_pkg::*;
#(
  parameter  int NUM_SURFS      = NUM_SURFS_DEF,
  parameter  int NUM_HOLD       = NUM_HOLD_DEF,
  parameter  int HOLDOFF_CYCLES = 16,
  parameter  int EVNUM_WIDTH    = EVNUM_WIDTH_DEF,
  localparam int BUF_W          = clog2(NUM_HOLD)
) (
  input  logic                          clk125_i,
  input  logic                          rst_n_i,
  input  logic                          enable_i,
  input  logic                          trig_i,
  input  logic                          buf_done_valid_i,
  input  logic [BUF_W-1:0]              buf_done_id_i,
  input  logic                          evnum_clear_i,
  output logic [NUM_HOLD*NUM_SURFS-1:0] hold_o,
  output logic                          event_valid_o,
  input  logic                          event_ready_i,
  output logic [BUF_W-1:0]              event_buf_o,
  output logic [EVNUM_WIDTH-1:0]        event_num_o,
  output logic                          full_o,
  output logic [15:0]                   reject_count_o,
  output logic                          err_release_o
);

  localparam int HO_W = clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HO_W-1:0] HOLDOFF_LOAD = HO_W'(HOLDOFF_CYCLES - 1);

  logic [NUM_HOLD-1:0]    held_q, held_d;
  logic [BUF_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [EVNUM_WIDTH-1:0] evnum_q, evnum_d;
  logic [HO_W-1:0]        holdoff_q, holdoff_d;
  logic [15:0]            reject_q, reject_d;
  logic                   err_q, err_d;
  logic                   accept;

  logic                   fifo_full, fifo_empty;
  logic [BUF_W:0]         fifo_count;

  always_comb begin
    full_o = held_q[wr_ptr_q];
    accept = trig_i && enable_i && !held_q[wr_ptr_q] && (holdoff_q == '0);

    // Clear before set: a release of the buffer being allocated can only
    // happen when that buffer is already free, so the allocation wins.
    held_d = held_q;
    if (buf_done_valid_i) held_d[buf_done_id_i] = 1'b0;
    if (accept)           held_d[wr_ptr_q]      = 1'b1;

    err_d    = err_q | (buf_done_valid_i && !held_q[buf_done_id_i]);
    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;

    evnum_d = evnum_q;
    if (evnum_clear_i) evnum_d = '0;
    else if (accept)   evnum_d = evnum_q + 1'b1;

    holdoff_d = holdoff_q;
    if (accept)                holdoff_d = HOLDOFF_LOAD;
    else if (holdoff_q != '0)  holdoff_d = holdoff_q - 1'b1;

    reject_d = reject_q;
    if (trig_i && !accept && (reject_q != 16'hFFFF)) reject_d = reject_q + 1'b1;
  end

  always_ff @(posedge clk125_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      held_q    <= '0;
      wr_ptr_q  <= '0;
      evnum_q   <= '0;
      holdoff_q <= '0;
      reject_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      held_q    <= held_d;
      wr_ptr_q  <= wr_ptr_d;
      evnum_q   <= evnum_d;
      holdoff_q <= holdoff_d;
      reject_q  <= reject_d;
      err_q     <= err_d;
    end
  end

  turf_event_fifo #(
    .WIDTH (BUF_W + EVNUM_WIDTH),
    .DEPTH (NUM_HOLD)
  ) u_fifo (
    .clk_i   (clk125_i),
    .rst_n_i (rst_n_i),
    .push_i  (accept),
    .data_i  ({wr_ptr_q, evnum_q}),
    .pop_i   (event_ready_i),
    .data_o  ({event_buf_o, event_num_o}),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign event_valid_o  = !fifo_empty;
  assign reject_count_o = reject_q;
  assign err_release_o  = err_q;

  generate
    for (genvar gi = 0; gi < NUM_SURFS; gi++) begin : g_surf
      assign hold_o[gi*NUM_HOLD +: NUM_HOLD] = held_q;
    end
  endgenerate

  // Records only exist for accepted triggers, so the queue should never be
  // asked to take a record while it is already full.
  always_ff @(posedge clk125_i) begin
    if (rst_n_i) begin
      assert (!(accept && fifo_full));
      assert (fifo_count <= (BUF_W + 1)'(NUM_HOLD));
    end
  end

endmodule
